// File: rtl/div_32_seq_if.sv
// Handshake and result bundle for the sequential 32-bit divider.
// The master issues start with operands; the slave returns quotient, remainder and flags.
interface div_32_seq_if;
    logic        start;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic [31:0] Y_hi;
    logic [31:0] Y_lo;
    logic        C;
    logic        V;
    logic        N;
    logic        Z;

    modport master (
        output start, S, T,
        input  busy, done, Y_hi, Y_lo, C, V, N, Z
    );

    modport slave (
        input  start, S, T,
        output busy, done, Y_hi, Y_lo, C, V, N, Z
    );
endinterface

// File: rtl/div_32_seq.sv
// Radix-2 restoring divider: quotient on Y_lo, remainder on Y_hi, ALU-style C/V/N/Z flags.
// Signed mode divides magnitudes and re-applies signs (truncate toward zero) in a final fix-up cycle.
module div_32_seq #(
    parameter int SIGNED = 1
) (
    input  logic         clk,
    input  logic         reset,
    div_32_seq_if.slave  bus
);
    localparam bit IS_SIGNED = (SIGNED != 0);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] dividend;
    logic [4:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic        div_zero;
    logic        ovf;

    logic        s_neg;
    logic        t_neg;
    logic [31:0] s_mag;
    logic [31:0] t_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operand magnitudes, one trial-subtract step, and sign restoration for the fix-up cycle.
    // shifted can exceed 32 bits only when the subtract succeeds, so rem itself stays 32 bits.
    always_comb begin
        s_neg   = IS_SIGNED && bus.S[31];
        t_neg   = IS_SIGNED && bus.T[31];
        s_mag   = s_neg ? -bus.S : bus.S;
        t_mag   = t_neg ? -bus.T : bus.T;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        q_fix   = sign_q ? -quo : quo;
        r_fix   = sign_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dividend <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.Y_hi <= '0;
            bus.Y_lo <= '0;
            bus.C    <= 1'b0;
            bus.V    <= 1'b0;
            bus.N    <= 1'b0;
            bus.Z    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividend <= bus.S;
                        dvs      <= t_mag;
                        quo      <= s_mag;
                        rem      <= '0;
                        count    <= '0;
                        sign_q   <= s_neg ^ t_neg;
                        sign_r   <= s_neg;
                        div_zero <= (bus.T == 32'd0);
                        ovf      <= IS_SIGNED && (bus.S == 32'h8000_0000) && (bus.T == 32'hFFFF_FFFF);
                        bus.busy <= 1'b1;
                        state    <= (bus.T == 32'd0) ? FIX : CALC;
                    end
                end

                CALC: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // A zero divisor bypasses the datapath and reports all-ones with the raw dividend.
                    if (div_zero) begin
                        bus.Y_lo <= 32'hFFFF_FFFF;
                        bus.Y_hi <= dividend;
                        bus.V    <= 1'b1;
                        bus.N    <= 1'b1;
                        bus.Z    <= 1'b0;
                    end else begin
                        bus.Y_lo <= q_fix;
                        bus.Y_hi <= r_fix;
                        bus.V    <= ovf;
                        bus.N    <= q_fix[31];
                        bus.Z    <= (q_fix == 32'd0);
                    end
                    bus.C    <= 1'b0;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_32_seq.sv
// Directed bench driving a signed and an unsigned divider with identical stimulus,
// comparing against hand-computed quotients, remainders, flags and latencies.
module tb_div_32_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] s_in;
    logic [31:0] t_in;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          lat2;
    int          busy_cnt;

    div_32_seq_if sif();
    div_32_seq_if uif();

    assign sif.start = start;
    assign sif.S     = s_in;
    assign sif.T     = t_in;
    assign uif.start = start;
    assign uif.S     = s_in;
    assign uif.T     = t_in;

    div_32_seq #(.SIGNED(1)) u_dut_s (.clk(clk), .reset(reset), .bus(sif.slave));
    div_32_seq #(.SIGNED(0)) u_dut_u (.clk(clk), .reset(reset), .bus(uif.slave));

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one edge, then scrambles them to prove they were latched.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] t);
        s_in  = s;
        t_in  = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_in  = 32'hDEAD_BEEF;
        t_in  = 32'h0000_0003;
    endtask

    task automatic waitDone(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = sif.busy ? 1 : 0;
        while (!sif.done && cycles < 100) begin
            tick();
            cycles++;
            if (sif.busy) busy_cycles++;
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] s, input logic [31:0] t,
                           input int exp_lat,
                           input logic [31:0] s_hi, input logic [31:0] s_lo, input logic [3:0] s_fl,
                           input logic [31:0] u_hi, input logic [31:0] u_lo, input logic [3:0] u_fl);
        int l;
        int b;
        applyStimulus(s, t);
        waitDone(l, b);
        checkOutput({tag, " latency"}, 64'(l), 64'(exp_lat));
        checkOutput({tag, " busy cycles"}, 64'(b), 64'(exp_lat));
        checkOutput({tag, " done both"}, {62'd0, sif.done, uif.done}, 64'd3);
        checkOutput({tag, " signed hi/lo"}, {sif.Y_hi, sif.Y_lo}, {s_hi, s_lo});
        checkOutput({tag, " signed CVNZ"}, {60'd0, sif.C, sif.V, sif.N, sif.Z}, {60'd0, s_fl});
        checkOutput({tag, " unsigned hi/lo"}, {uif.Y_hi, uif.Y_lo}, {u_hi, u_lo});
        checkOutput({tag, " unsigned CVNZ"}, {60'd0, uif.C, uif.V, uif.N, uif.Z}, {60'd0, u_fl});
        tick();
        checkOutput({tag, " done pulse ends"}, {62'd0, sif.done, uif.done}, 64'd0);
        checkOutput({tag, " signed hold"}, {sif.Y_hi, sif.Y_lo}, {s_hi, s_lo});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        s_in  = '0;
        t_in  = '0;
        #12;
        checkOutput("reset outputs", {sif.Y_hi, sif.Y_lo}, 64'd0);
        checkOutput("reset ctrl/flags", {58'd0, sif.busy, sif.done, sif.C, sif.V, sif.N, sif.Z}, 64'd0);
        reset = 1'b0;
        tick();

        runCase("100/7", 32'd100, 32'd7, 33,
                32'd2, 32'd14, 4'b0000, 32'd2, 32'd14, 4'b0000);
        runCase("-100/7", 32'hFFFF_FF9C, 32'd7, 33,
                32'hFFFF_FFFE, 32'hFFFF_FFF2, 4'b0010, 32'd2, 32'h2492_4916, 4'b0000);
        runCase("3/-5", 32'd3, 32'hFFFF_FFFB, 33,
                32'd3, 32'd0, 4'b0001, 32'd3, 32'd0, 4'b0001);
        runCase("div0", 32'h1234_5678, 32'd0, 1,
                32'h1234_5678, 32'hFFFF_FFFF, 4'b0110, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0110);
        runCase("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 33,
                32'd0, 32'h8000_0000, 4'b0110, 32'h8000_0000, 32'd0, 4'b0001);
        runCase("max/2", 32'hFFFF_FFFF, 32'd2, 33,
                32'hFFFF_FFFF, 32'd0, 4'b0001, 32'd1, 32'h7FFF_FFFF, 4'b0000);

        // A start pulse during a busy divide must not restart or queue anything.
        applyStimulus(32'd1000, 32'd10);
        repeat (9) tick();
        applyStimulus(32'd7, 32'd2);
        waitDone(lat, busy_cnt);
        checkOutput("ignored start latency", 64'(lat), 64'd23);
        checkOutput("ignored start result", {sif.Y_hi, sif.Y_lo}, {32'd0, 32'd100});
        checkOutput("ignored start unsigned", {uif.Y_hi, uif.Y_lo}, {32'd0, 32'd100});

        // Start on the done cycle is accepted.
        applyStimulus(32'd50, 32'd7);
        checkOutput("done single cycle", {63'd0, sif.done}, 64'd0);
        waitDone(lat2, busy_cnt);
        checkOutput("back-to-back latency", 64'(lat2), 64'd33);
        checkOutput("back-to-back result", {sif.Y_hi, sif.Y_lo}, {32'd1, 32'd7});

        // Asynchronous reset in the middle of a divide.
        applyStimulus(32'd1000, 32'd10);
        repeat (14) tick();
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async reset outputs", {sif.Y_hi, sif.Y_lo}, 64'd0);
        checkOutput("async reset ctrl/flags", {58'd0, sif.busy, sif.done, sif.C, sif.V, sif.N, sif.Z}, 64'd0);
        checkOutput("async reset unsigned", {uif.Y_hi, uif.Y_lo}, 64'd0);
        repeat (3) tick();
        reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sif.done) lat++;
        end
        checkOutput("no done after abort", 64'(lat), 64'd0);

        runCase("50/5", 32'd50, 32'd5, 33,
                32'd0, 32'd10, 4'b0000, 32'd0, 32'd10, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
